// File: rtl/main_memory_arbiter.sv
// Fixed-priority (dcache first) line arbiter in front of an emulated main memory with fixed latency.
// Optional MEM_ARB_STATS_EN adds saturating grant/blocked counters.
module main_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int MEM_LINES  = 1024,
  parameter int LATENCY    = 10,
  parameter int LAT_LOG    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  icache_req_valid,
  input  logic [ADDR_WIDTH-1:0] icache_req_addr,
  output logic                  icache_rsp_valid,
  output logic [LINE_WIDTH-1:0] icache_rsp_data,
  input  logic                  dcache_req_valid,
  input  logic [ADDR_WIDTH-1:0] dcache_req_addr,
  input  logic                  dcache_req_wr,
  input  logic [LINE_WIDTH-1:0] dcache_req_data,
  output logic                  dcache_rsp_valid,
  output logic [LINE_WIDTH-1:0] dcache_rsp_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_icache_grants,
  output logic [31:0]           stat_dcache_grants,
  output logic [31:0]           stat_icache_blocked
`endif
);

  localparam int OFF     = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W   = $clog2(MEM_LINES);
  localparam bit LAT_ONE = (LATENCY == 1);
  localparam int ACC_INT = (LATENCY >= 2) ? (LATENCY - 2) : 0;
  localparam logic [LAT_LOG-1:0] CNT_LAST = LAT_LOG'(LATENCY - 1);
  localparam logic [LAT_LOG-1:0] CNT_ACC  = LAT_LOG'(ACC_INT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [LAT_LOG-1:0]   r_cnt;
  logic [LAT_LOG-1:0]   w_cnt_next;

  logic                 r_who_d;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_wr;
  logic [LINE_WIDTH-1:0] r_wdata;

  logic                 w_grant_d;
  logic                 w_grant_i;
  logic                 w_grant;
  logic                 w_access;
  logic                 w_acc_who_d;
  logic [IDX_W-1:0]     w_acc_idx;
  logic                 w_acc_wr;
  logic [LINE_WIDTH-1:0] w_acc_data;
  logic [IDX_W-1:0]     w_d_idx;
  logic [IDX_W-1:0]     w_i_idx;
  logic                 w_unused;

  logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];

  logic                 r_i_rsp_valid;
  logic                 r_d_rsp_valid;
  logic [LINE_WIDTH-1:0] r_i_rsp_data;
  logic [LINE_WIDTH-1:0] r_d_rsp_data;

  // Only the line-index field matters; offset and upper bits alias.
  assign w_d_idx  = dcache_req_addr[OFF +: IDX_W];
  assign w_i_idx  = icache_req_addr[OFF +: IDX_W];
  assign w_unused = ^{icache_req_addr, dcache_req_addr};

  assign w_grant_d = (r_state == S_IDLE) && dcache_req_valid;
  assign w_grant_i = (r_state == S_IDLE) && !dcache_req_valid && icache_req_valid;
  assign w_grant   = w_grant_d || w_grant_i;

  // In IDLE the access fields come straight from the winner so LATENCY=1 can access in the grant cycle.
  always_comb begin
    w_acc_who_d = r_who_d;
    w_acc_idx   = r_idx;
    w_acc_wr    = r_wr;
    w_acc_data  = r_wdata;
    if (r_state == S_IDLE) begin
      w_acc_who_d = dcache_req_valid;
      w_acc_idx   = dcache_req_valid ? w_d_idx : w_i_idx;
      w_acc_wr    = dcache_req_valid && dcache_req_wr;
      w_acc_data  = dcache_req_data;
    end
  end

  // The access is registered one cycle before the response is visible, i.e. at grant+LATENCY-1.
  assign w_access = !reset && (LAT_ONE ? w_grant
                                       : ((r_state == S_WAIT) && (r_cnt == CNT_ACC)));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = S_WAIT;
          w_cnt_next   = '0;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt + LAT_LOG'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_who_d <= 1'b0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_who_d <= w_acc_who_d;
      r_idx   <= w_acc_idx;
      r_wr    <= w_acc_wr;
      r_wdata <= w_acc_data;
    end
  end

  // Backing array is never reset; a write only commits at its access cycle.
  always_ff @(posedge clock) begin
    if (w_access && w_acc_wr) begin
      r_mem[w_acc_idx] <= w_acc_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_rsp_valid <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      r_i_rsp_data  <= '0;
      r_d_rsp_data  <= '0;
    end else begin
      r_i_rsp_valid <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      if (w_access) begin
        if (w_acc_who_d) begin
          r_d_rsp_valid <= 1'b1;
          r_d_rsp_data  <= w_acc_wr ? w_acc_data : r_mem[w_acc_idx];
        end else begin
          r_i_rsp_valid <= 1'b1;
          r_i_rsp_data  <= r_mem[w_acc_idx];
        end
      end
    end
  end

  assign icache_rsp_valid = r_i_rsp_valid;
  assign icache_rsp_data  = r_i_rsp_data;
  assign dcache_rsp_valid = r_d_rsp_valid;
  assign dcache_rsp_data  = r_d_rsp_data;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_ig;
  logic [31:0] r_stat_dg;
  logic [31:0] r_stat_ib;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_ig <= '0;
      r_stat_dg <= '0;
      r_stat_ib <= '0;
    end else begin
      if (w_grant_i && (r_stat_ig != '1)) begin
        r_stat_ig <= r_stat_ig + 32'd1;
      end
      if (w_grant_d && (r_stat_dg != '1)) begin
        r_stat_dg <= r_stat_dg + 32'd1;
      end
      if (icache_req_valid && !w_grant_i && (r_stat_ib != '1)) begin
        r_stat_ib <= r_stat_ib + 32'd1;
      end
    end
  end

  assign stat_icache_grants  = r_stat_ig;
  assign stat_dcache_grants  = r_stat_dg;
  assign stat_icache_blocked = r_stat_ib;
`endif

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Bench for main_memory_arbiter: a schedule-level reference model checked every cycle plus directed literal checks.
module tb_main_memory_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int ML  = 1024;
  localparam int LAT = 10;
  localparam int LL  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          icache_req_valid = 1'b0;
  logic [AW-1:0] icache_req_addr = '0;
  logic          icache_rsp_valid;
  logic [LW-1:0] icache_rsp_data;
  logic          dcache_req_valid = 1'b0;
  logic [AW-1:0] dcache_req_addr = '0;
  logic          dcache_req_wr = 1'b0;
  logic [LW-1:0] dcache_req_data = '0;
  logic          dcache_rsp_valid;
  logic [LW-1:0] dcache_rsp_data;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   stat_icache_grants;
  logic [31:0]   stat_dcache_grants;
  logic [31:0]   stat_icache_blocked;
`endif

  main_memory_arbiter #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_LINES(ML), .LATENCY(LAT), .LAT_LOG(LL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .icache_req_valid(icache_req_valid),
    .icache_req_addr(icache_req_addr),
    .icache_rsp_valid(icache_rsp_valid),
    .icache_rsp_data(icache_rsp_data),
    .dcache_req_valid(dcache_req_valid),
    .dcache_req_addr(dcache_req_addr),
    .dcache_req_wr(dcache_req_wr),
    .dcache_req_data(dcache_req_data),
    .dcache_rsp_valid(dcache_rsp_valid),
    .dcache_rsp_data(dcache_rsp_data)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_icache_grants(stat_icache_grants),
    .stat_dcache_grants(stat_dcache_grants),
    .stat_icache_blocked(stat_icache_blocked)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [LW-1:0] mem_m [int];
  bit            model_ready = 0;
  int            busy_until = 0;
  bit            pend_v = 0;
  bit            pend_d;
  int            pend_idx;
  bit            pend_wr;
  logic [LW-1:0] pend_data;
  int            pend_due;
  bit            exp_iv = 0, exp_dv = 0;
  logic [LW-1:0] exp_idata = '0, exp_ddata = '0;
  bit            i_known = 1, d_known = 1;
  logic [31:0]   st_ig = 0, st_dg = 0, st_ib = 0;

  int            i_pulses = 0, d_pulses = 0;
  int            i_last_cyc = -1, d_last_cyc = -1;
  logic [LW-1:0] i_last_data = '0, d_last_data = '0;

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / (LW / 8)) % ML);
  endfunction

  always @(negedge clock) begin
    bit gi;
    if (model_ready) begin
      chk("icache_rsp_valid", {127'd0, icache_rsp_valid}, {127'd0, exp_iv});
      chk("dcache_rsp_valid", {127'd0, dcache_rsp_valid}, {127'd0, exp_dv});
      if (i_known) chk("icache_rsp_data", icache_rsp_data, exp_idata);
      if (d_known) chk("dcache_rsp_data", dcache_rsp_data, exp_ddata);
`ifdef MEM_ARB_STATS_EN
      chk("stat_icache_grants", {96'd0, stat_icache_grants}, {96'd0, st_ig});
      chk("stat_dcache_grants", {96'd0, stat_dcache_grants}, {96'd0, st_dg});
      chk("stat_icache_blocked", {96'd0, stat_icache_blocked}, {96'd0, st_ib});
`endif
    end
    if (icache_rsp_valid === 1'b1) begin
      i_pulses++; i_last_cyc = cyc; i_last_data = icache_rsp_data;
    end
    if (dcache_rsp_valid === 1'b1) begin
      d_pulses++; d_last_cyc = cyc; d_last_data = dcache_rsp_data;
    end
    // predict what the outputs must be in the next cycle
    exp_iv = 0; exp_dv = 0; gi = 0;
    if (reset) begin
      pend_v = 0; busy_until = cyc + 1;
      exp_idata = '0; exp_ddata = '0; i_known = 1; d_known = 1;
      st_ig = 0; st_dg = 0; st_ib = 0;
      model_ready = 1;
    end else begin
      if (cyc >= busy_until) begin
        if (dcache_req_valid) begin
          pend_v = 1; pend_d = 1; pend_idx = line_of(dcache_req_addr);
          pend_wr = dcache_req_wr; pend_data = dcache_req_data;
          pend_due = cyc + LAT; busy_until = cyc + LAT + 2;
          if (st_dg != 32'hFFFF_FFFF) st_dg++;
        end else if (icache_req_valid) begin
          pend_v = 1; pend_d = 0; pend_idx = line_of(icache_req_addr);
          pend_wr = 0; pend_data = '0;
          pend_due = cyc + LAT; busy_until = cyc + LAT + 2; gi = 1;
          if (st_ig != 32'hFFFF_FFFF) st_ig++;
        end
      end
      if (icache_req_valid && !gi && st_ib != 32'hFFFF_FFFF) st_ib++;
      if (pend_v && pend_due == cyc + 1) begin
        logic [LW-1:0] line;
        bit known;
        pend_v = 0;
        if (pend_wr) begin
          mem_m[pend_idx] = pend_data; line = pend_data; known = 1;
        end else begin
          known = mem_m.exists(pend_idx);
          line = known ? mem_m[pend_idx] : '0;
        end
        if (pend_d) begin
          exp_dv = 1; exp_ddata = line; d_known = known;
        end else begin
          exp_iv = 1; exp_idata = line; i_known = known;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic dreq(input logic [AW-1:0] a, input logic wr, input logic [LW-1:0] d, output int g);
    dcache_req_valid = 1; dcache_req_addr = a; dcache_req_wr = wr; dcache_req_data = d;
    g = cyc;
    tick();
    dcache_req_valid = 0;
  endtask

  task automatic ireq(input logic [AW-1:0] a, output int g);
    icache_req_valid = 1; icache_req_addr = a;
    g = cyc;
    tick();
    icache_req_valid = 0;
  endtask

  task automatic settle();
    repeat (LAT + 2) tick();
  endtask

  localparam logic [LW-1:0] L_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] L_1  = {16{8'h11}};
  localparam logic [LW-1:0] L_2  = {16{8'h22}};
  localparam logic [LW-1:0] L_3  = {16{8'h3C}};

  initial begin
    int g, g2, p0;
    repeat (3) tick();
    reset = 0;
    chk("reset_i_valid", {127'd0, icache_rsp_valid}, '0);
    chk("reset_d_valid", {127'd0, dcache_rsp_valid}, '0);
    chk("reset_i_data", icache_rsp_data, '0);
    chk("reset_d_data", dcache_rsp_data, '0);

    // Test 1: write then icache read of the same line
    p0 = d_pulses;
    dreq(32'h40, 1'b1, L_A5, g); settle();
    chk("t1_d_latency", LW'(d_last_cyc - g), LW'(10));
    chk("t1_d_pulses", LW'(d_pulses - p0), LW'(1));
    chk("t1_d_data", d_last_data, L_A5);
    ireq(32'h40, g); settle();
    chk("t1_i_latency", LW'(i_last_cyc - g), LW'(10));
    chk("t1_i_data", i_last_data, L_A5);

    // preload lines used below
    dreq(32'h100, 1'b1, L_1, g); settle();
    dreq(32'h200, 1'b1, L_2, g); settle();
    dreq(32'h80, 1'b1, L_3, g); settle();

    // Test 3: aliasing modulo MEM_LINES
    dreq(32'h0, 1'b1, LW'(1), g); settle();
    dreq(32'h4000, 1'b0, '0, g); settle();
    chk("t3_alias_data", d_last_data, LW'(1));

    // Test 2 / 6: simultaneous requests after a fresh reset of counters
    reset = 1; tick(); reset = 0;
    icache_req_valid = 1; icache_req_addr = 32'h100;
    dcache_req_valid = 1; dcache_req_addr = 32'h200; dcache_req_wr = 0;
    g = cyc;
    tick();
    dcache_req_valid = 0;
    repeat (11) tick();
    tick();
    icache_req_valid = 0;
    settle();
    chk("t2_d_latency", LW'(d_last_cyc - g), LW'(10));
    chk("t2_d_data", d_last_data, L_2);
    chk("t2_i_latency", LW'(i_last_cyc - g), LW'(22));
    chk("t2_i_data", i_last_data, L_1);
`ifdef MEM_ARB_STATS_EN
    chk("t6_stat_dg", {96'd0, stat_dcache_grants}, LW'(1));
    chk("t6_stat_ig", {96'd0, stat_icache_grants}, LW'(1));
    chk("t6_stat_ib", {96'd0, stat_icache_blocked}, LW'(12));
`endif

    // Test 4: reset mid-write aborts it
    p0 = d_pulses;
    dreq(32'h80, 1'b1, LW'(8'hFF), g);
    repeat (4) tick();
    reset = 1; tick(); reset = 0;
    settle();
    chk("t4_no_pulse", LW'(d_pulses - p0), LW'(0));
    dreq(32'h80, 1'b0, '0, g2); settle();
    chk("t4_idle_latency", LW'(d_last_cyc - g2), LW'(10));
    chk("t4_prior_data", d_last_data, L_3);

    // Test 5: icache holds valid through DONE
    p0 = i_pulses;
    icache_req_valid = 1; icache_req_addr = 32'h40;
    g = cyc;
    repeat (12) tick();
    icache_req_valid = 0;
    repeat (15) tick();
    chk("t5_one_pulse", LW'(i_pulses - p0), LW'(1));
    chk("t5_latency", LW'(i_last_cyc - g), LW'(10));
    chk("t5_data", i_last_data, L_A5);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/main_memory_arbiter.md
Name: main_memory_arbiter

Overview:
- Sits directly downstream of the instruction cache's miss port and the data cache's miss/writeback port.
- Arbitrates their line requests with fixed priority: dcache first.
- Services each granted request from an internal line-granular backing array after a fixed, emulated main-memory latency.
- Returns a single-cycle response pulse to the requester.

Parameters:
- ADDR_WIDTH, 32, byte address width of miss requests.
- LINE_WIDTH, 128, cache line width in bits. Power of two, at least 8.
- MEM_LINES, 1024, lines in the backing array. Power of two.
- LATENCY, 10, cycles from grant to response pulse. Minimum 1.
- LAT_LOG, 4, counter width. Must satisfy 2^LAT_LOG > LATENCY.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- icache_req_valid  in  1  icache miss request, held until serviced
- icache_req_addr  in  ADDR_WIDTH  icache miss byte address
- icache_rsp_valid  out  1  one-cycle pulse, line returned
- icache_rsp_data  out  LINE_WIDTH  returned line
- dcache_req_valid  in  1  dcache request, held until serviced
- dcache_req_addr  in  ADDR_WIDTH  dcache byte address
- dcache_req_wr  in  1  1 = line write (writeback), 0 = line read
- dcache_req_data  in  LINE_WIDTH  writeback line
- dcache_rsp_valid  out  1  one-cycle pulse, read data or write ack
- dcache_rsp_data  out  LINE_WIDTH  read line; on a write, echoes the written line

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Line index: addr[OFF +: log2(MEM_LINES)], where OFF = log2(LINE_WIDTH/8).
  - Offset bits are ignored.
  - Upper address bits are ignored, so addresses alias modulo MEM_LINES.
- State machine: IDLE, WAIT, DONE.
- IDLE:
  - If dcache_req_valid: grant D.
  - Else if icache_req_valid: grant I.
  - On a grant, latch requester id, index, wr and data; clear the counter; go to WAIT.
  - If neither is valid, stay in IDLE.
- WAIT:
  - Counter increments each cycle.
  - When the counter reaches LATENCY-1, perform the access and go to DONE.
  - Reads capture array[index] into the response register.
  - Writes update array[index] and echo the data into the response register.
  - Timing: the granting requester's rsp_valid is high, registered, in cycle t+LATENCY, where t is the IDLE grant cycle.
  - With LATENCY=1, WAIT lasts zero extra cycles: the response is registered at the end of the grant cycle.
- DONE:
  - Lasts exactly one cycle (t+LATENCY+1). No grants are taken; then go to IDLE.
  - The requester must drop req_valid by t+LATENCY+1. A valid still high in IDLE is treated as a new request.
- Responses:
  - Only the granted requester's rsp_valid pulses. The other rsp_valid stays 0.
  - rsp_data holds its last value between pulses.
- Request inputs are ignored while in WAIT or DONE: no queuing, no preemption.
- Simultaneous requests: dcache always wins. The icache keeps valid high and is granted at the first IDLE with no dcache request. Icache starvation under continuous dcache traffic is accepted.
- Ordering: a write followed by a read of the same line returns the new data.
- Reset values: state=IDLE, counter=0, both rsp_valid=0, both rsp_data=0. The backing array is not reset.
- Reset mid-operation: the outstanding access is aborted, no response pulse is produced, and an in-flight write is not committed.
- Back-to-back throughput: one request per LATENCY+2 cycles.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds three 32-bit outputs, each reset to 0, saturating at all-ones.
  - stat_icache_grants: icache grants.
  - stat_dcache_grants: dcache grants.
  - stat_icache_blocked: cycles with icache_req_valid=1 and no icache grant that cycle.
- Not defined: these ports and registers are absent, and functional behaviour is identical.

Test Plan:
- Parameters for all tests: LATENCY=10, LINE_WIDTH=128, MEM_LINES=1024.
- Test 1: dcache write addr 0x00000040, data 0xA5..A5, granted cycle t -> dcache_rsp_valid=1 only at t+10, rsp_data=0xA5..A5. Then icache read 0x00000040 -> icache_rsp_valid at grant+10, data 0xA5..A5.
- Test 2: both valid in the same IDLE cycle (icache 0x100, dcache read 0x200) -> dcache granted first, dcache_rsp at t+10. Icache granted at t+12, icache_rsp at t+22. No overlap of pulses.
- Test 3: write 0x1 to addr 0x0, then read addr 0x4000 (aliases to index 0) -> read returns 0x1.
- Test 4: reset asserted at grant+5 of a dcache write of 0xFF to 0x80 -> no rsp pulse, state IDLE. A subsequent read of 0x80 returns the prior contents, not 0xFF.
- Test 5: icache holds valid through DONE, i.e. does not drop until t+11 -> no grant at t+11. Valid dropped at t+11 -> arbiter idle at t+12 with no spurious grant.
- Test 6 (MEM_ARB_STATS_EN defined): run the Test 2 sequence -> stat_dcache_grants=1, stat_icache_grants=1, stat_icache_blocked=12.
